// File: rtl/uno_pkg.sv
// Shared UNO card types: colors, value codes, the packed card code and dealer states.
// Imported by the dealer, the ID decoder and downstream game/display blocks.
package uno_pkg;

   localparam int DECK_SIZE = 108;
   localparam int CARD_ID_W = 7;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2,
      BLUE   = 2'd3
   } color_e;

   localparam logic [3:0] SKIP    = 4'd10;
   localparam logic [3:0] REVERSE = 4'd11;
   localparam logic [3:0] DRAW2   = 4'd12;
   localparam logic [3:0] WILD    = 4'd13;
   localparam logic [3:0] WILD4   = 4'd14;
   localparam logic [3:0] ILLEGAL = 4'd15;

   typedef struct packed {
      color_e     color;
      logic [3:0] value;
   } card_t;

   typedef enum logic [1:0] {
      S_UNLOADED = 2'd0,
      S_IDLE     = 2'd1,
      S_DEAL     = 2'd2
   } dealer_state_e;

endpackage

// File: rtl/uno_card_decode.sv
// Combinational card-ID to {color, value} decoder; the divide-by-25 is a comparator chain
// so each colour band maps to a 5-bit remainder.
module uno_card_decode
   import uno_pkg::*;
#(
   parameter int ID_W    = CARD_ID_W,
   parameter int N_CARDS = DECK_SIZE
) (
   input  logic [ID_W-1:0] id,
   output card_t           card
);

   color_e     color_s;
   logic [3:0] value_s;
   logic [4:0] r_s;

   // Pick colour band and remainder, then map remainder pairs onto 1-12
   always_comb begin
      color_s = RED;
      value_s = ILLEGAL;
      r_s     = 5'd0;
      if (id >= ID_W'(N_CARDS)) begin
         value_s = ILLEGAL;
      end else if (id >= ID_W'(104)) begin
         value_s = WILD4;
      end else if (id >= ID_W'(100)) begin
         value_s = WILD;
      end else begin
         if (id < ID_W'(25)) begin
            color_s = RED;
            r_s     = 5'(id);
         end else if (id < ID_W'(50)) begin
            color_s = YELLOW;
            r_s     = 5'(id - ID_W'(25));
         end else if (id < ID_W'(75)) begin
            color_s = GREEN;
            r_s     = 5'(id - ID_W'(50));
         end else begin
            color_s = BLUE;
            r_s     = 5'(id - ID_W'(75));
         end
         value_s = (r_s == 5'd0) ? 4'd0 : 4'((r_s + 5'd1) >> 1);
      end
   end

   assign card = '{color: color_s, value: value_s};

endmodule

// File: rtl/uno_card_dealer.sv
// Snapshots a shuffled deck and deals 1-4 cards per request from the top of the pile,
// presenting each as a raw ID and a decoded card code over a valid/ready handshake.
module uno_card_dealer #(
   parameter int DECK_SIZE = uno_pkg::DECK_SIZE,
   parameter int ID_W      = uno_pkg::CARD_ID_W
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic [ID_W-1:0] i_deck [DECK_SIZE],
   input  logic            i_req,
   input  logic [2:0]      i_req_n,
   output logic            o_req_ready,
   output logic            o_card_valid,
   input  logic            i_card_ready,
   output logic [5:0]      o_card,
   output logic [ID_W-1:0] o_card_id,
   output logic            o_last,
   output logic [ID_W-1:0] o_remaining,
   output logic            o_empty,
   output logic            o_short
);
   import uno_pkg::*;

   logic [ID_W-1:0] deck_r [DECK_SIZE];
   dealer_state_e   state_r, state_nx;
   logic [ID_W-1:0] ptr_r, ptr_nx;
   logic [ID_W-1:0] rem_r, rem_nx;
   logic [2:0]      n_r, n_nx;
   logic            short_r, short_nx;
   logic [2:0]      req_n_s;
   card_t           card_s;

   function automatic logic [2:0] clamp_n(input logic [2:0] n);
      if (n == 3'd0) begin
         return 3'd1;
      end else if (n > 3'd4) begin
         return 3'd4;
      end else begin
         return n;
      end
   endfunction

   assign req_n_s = clamp_n(i_req_n);

   // Next-state and pile bookkeeping; a load overrides requests and handshakes
   always_comb begin
      state_nx = state_r;
      ptr_nx   = ptr_r;
      rem_nx   = rem_r;
      n_nx     = n_r;
      short_nx = short_r;
      if (i_load) begin
         state_nx = S_IDLE;
         ptr_nx   = '0;
         rem_nx   = ID_W'(DECK_SIZE);
         n_nx     = 3'd0;
         short_nx = 1'b0;
      end else begin
         case (state_r)
            S_UNLOADED: begin
               state_nx = S_UNLOADED;
            end
            S_IDLE: begin
               if (i_req && (rem_r == '0)) begin
                  short_nx = 1'b1;
               end else if (i_req) begin
                  if (ID_W'(req_n_s) > rem_r) begin
                     short_nx = 1'b1;
                     n_nx     = rem_r[2:0];
                  end else begin
                     n_nx     = req_n_s;
                  end
                  state_nx = S_DEAL;
               end else begin
                  state_nx = S_IDLE;
               end
            end
            S_DEAL: begin
               if (i_card_ready) begin
                  ptr_nx = ptr_r + ID_W'(1);
                  rem_nx = rem_r - ID_W'(1);
                  n_nx   = n_r - 3'd1;
                  state_nx = (n_r == 3'd1) ? S_IDLE : S_DEAL;
               end else begin
                  state_nx = S_DEAL;
               end
            end
            default: begin
               state_nx = S_UNLOADED;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= S_UNLOADED;
      end else begin
         state_r <= state_nx;
      end
   end

   // Pile pointer, remaining count, cards left in this request, sticky short flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_r   <= '0;
         rem_r   <= '0;
         n_r     <= 3'd0;
         short_r <= 1'b0;
      end else begin
         ptr_r   <= ptr_nx;
         rem_r   <= rem_nx;
         n_r     <= n_nx;
         short_r <= short_nx;
      end
   end

   // Deck snapshot
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DECK_SIZE; i++) begin
            deck_r[i] <= '0;
         end
      end else if (i_load) begin
         deck_r <= i_deck;
      end
   end

   uno_card_decode #(
      .ID_W    (ID_W),
      .N_CARDS (DECK_SIZE)
   ) u_decode (
      .id   (o_card_id),
      .card (card_s)
   );

   assign o_req_ready  = (state_r == S_IDLE);
   assign o_card_valid = (state_r == S_DEAL);
   assign o_last       = o_card_valid && (n_r == 3'd1);
   assign o_card_id    = o_card_valid ? deck_r[ptr_r] : '0;
   assign o_card       = card_s;
   assign o_remaining  = rem_r;
   assign o_empty      = (rem_r == '0);
   assign o_short      = short_r;

endmodule

// File: tb/tb_uno_card_dealer.sv
// Randomized bench for uno_card_dealer against a pile model that decodes IDs arithmetically.
module tb_uno_card_dealer;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [6:0] deck_v [108];
   logic       req;
   logic [2:0] req_n;
   logic       req_ready;
   logic       card_valid;
   logic       card_ready;
   logic [5:0] card;
   logic [6:0] card_id;
   logic       last;
   logic [6:0] remaining;
   logic       empty;
   logic       short_f;

   int checks = 0;
   int errors = 0;
   int mdeck [108];
   int mptr  = 0;
   int mrem  = 0;
   int mshort = 0;

   uno_card_dealer dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_load       (load),
      .i_deck       (deck_v),
      .i_req        (req),
      .i_req_n      (req_n),
      .o_req_ready  (req_ready),
      .o_card_valid (card_valid),
      .i_card_ready (card_ready),
      .o_card       (card),
      .o_card_id    (card_id),
      .o_last       (last),
      .o_remaining  (remaining),
      .o_empty      (empty),
      .o_short      (short_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_card(input int id);
      if (id >= 108) return 15;
      if (id >= 104) return 14;
      if (id >= 100) return 13;
      if ((id % 25) == 0) return (id / 25) * 16;
      return (id / 25) * 16 + ((id % 25) + 1) / 2;
   endfunction

   task automatic shuffle_deck();
      for (int i = 0; i < 108; i++) deck_v[i] = 7'(i);
      for (int i = 107; i > 0; i--) begin
         int j;
         logic [6:0] t;
         j = $urandom_range(i, 0);
         t = deck_v[i];
         deck_v[i] = deck_v[j];
         deck_v[j] = t;
      end
   endtask

   task automatic do_load();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 108; i++) mdeck[i] = int'(deck_v[i]);
      mptr = 0;
      mrem = 108;
      mshort = 0;
      check("load_ready", req_ready, 1);
      check("load_rem", remaining, 108);
      check("load_short", short_f, 0);
      check("load_valid", card_valid, 0);
      check("load_empty", empty, 0);
   endtask

   task automatic draw(input int n, input int ready_pct);
      int k;
      int expn;
      int got;
      int cyc;
      logic rdy;
      k = (n == 0) ? 1 : ((n > 4) ? 4 : n);
      expn = (k < mrem) ? k : mrem;
      got = 0;
      cyc = 0;
      check("ready_before", req_ready, 1);
      req = 1'b1;
      req_n = 3'(n);
      if (k > mrem) mshort = 1;
      @(negedge clk);
      req = 1'b0;
      while (got < expn && cyc < 200) begin
         cyc++;
         check("valid", card_valid, 1);
         check("card_id", card_id, mdeck[mptr]);
         check("card", card, ref_card(mdeck[mptr]));
         check("last", last, (got == expn - 1) ? 1 : 0);
         check("rem_deal", remaining, mrem);
         rdy = ($urandom_range(99, 0) < ready_pct);
         card_ready = rdy;
         if (rdy) begin
            got++;
            mptr++;
            mrem--;
         end
         @(negedge clk);
      end
      if (got < expn) check("deal_timeout", 0, 1);
      card_ready = 1'b0;
      check("valid_after", card_valid, 0);
      check("ready_after", req_ready, 1);
      check("rem_after", remaining, mrem);
      check("empty_after", empty, (mrem == 0) ? 1 : 0);
      check("short_after", short_f, mshort);
   endtask

   initial begin
      rst_n = 1'b0;
      load = 1'b0;
      req = 1'b0;
      req_n = 3'd1;
      card_ready = 1'b0;
      for (int i = 0; i < 108; i++) deck_v[i] = 7'd0;
      #12;
      check("rst_ready", req_ready, 0);
      check("rst_valid", card_valid, 0);
      check("rst_empty", empty, 1);
      check("rst_rem", remaining, 0);
      check("rst_short", short_f, 0);
      check("rst_card", card, 0);
      check("rst_id", card_id, 0);
      check("rst_last", last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("unloaded_ignore_req", card_valid, 0);
      check("unloaded_ready", req_ready, 0);

      // Identity deck, five single draws
      for (int i = 0; i < 108; i++) deck_v[i] = 7'(i);
      do_load();
      for (int i = 0; i < 5; i++) draw(1, 100);
      check("rem_103", remaining, 103);

      // Special IDs and a four-card burst, then an illegal ID
      shuffle_deck();
      deck_v[0] = 7'd24;
      deck_v[1] = 7'd25;
      deck_v[2] = 7'd100;
      deck_v[3] = 7'd107;
      deck_v[4] = 7'd120;
      do_load();
      draw(4, 100);
      check("rem_104", remaining, 104);
      draw(1, 100);

      // Backpressure and random draw sizes down to two cards, then exhaustion
      shuffle_deck();
      do_load();
      draw(2, 25);
      while (mrem > 6) draw($urandom_range(7, 0), 60);
      while (mrem > 2) draw(1, 100);
      draw(4, 100);
      check("exhaust_short", short_f, 1);
      check("exhaust_empty", empty, 1);
      draw(3, 100);

      // Load abort while the 2nd card of a short 4-card request is pending
      shuffle_deck();
      do_load();
      while (mrem > 3) draw(1, 100);
      req = 1'b1;
      req_n = 3'd4;
      card_ready = 1'b1;
      mshort = 1;
      @(negedge clk);
      req = 1'b0;
      check("abort_v1", card_valid, 1);
      check("abort_id1", card_id, mdeck[mptr]);
      check("abort_short_set", short_f, 1);
      mptr++;
      mrem--;
      @(negedge clk);
      card_ready = 1'b0;
      check("abort_v2", card_valid, 1);
      check("abort_id2", card_id, mdeck[mptr]);
      check("abort_last2", last, 0);
      shuffle_deck();
      load = 1'b1;
      req = 1'b1;
      card_ready = 1'b1;
      @(negedge clk);
      load = 1'b0;
      req = 1'b0;
      card_ready = 1'b0;
      for (int i = 0; i < 108; i++) mdeck[i] = int'(deck_v[i]);
      mptr = 0;
      mrem = 108;
      mshort = 0;
      check("abort_valid", card_valid, 0);
      check("abort_ready", req_ready, 1);
      check("abort_rem", remaining, 108);
      check("abort_short", short_f, 0);
      draw(1, 100);

      // Asynchronous reset in the middle of a deal
      req = 1'b1;
      req_n = 3'd4;
      @(negedge clk);
      req = 1'b0;
      check("mid_valid", card_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_valid", card_valid, 0);
      check("arst_ready", req_ready, 0);
      check("arst_empty", empty, 1);
      check("arst_rem", remaining, 0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 1'b1;
      req_n = 3'd2;
      @(negedge clk);
      req = 1'b0;
      check("post_rst_valid", card_valid, 0);
      check("post_rst_ready", req_ready, 0);
      shuffle_deck();
      do_load();
      draw(3, 80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uno_card_dealer.md
Name: uno_card_dealer

Overview:
- Reads the shuffled deck produced by the shuffler and deals cards from the top of the draw pile.
- On load, snapshots the 108 card IDs. It then serves draw requests of 1-4 cards (normal draw, draw two, wild draw four, initial hand dealing in 4-card bursts).
- It decodes each 7-bit card ID into the 6-bit card code {color[1:0], value[3:0]} used by the game-logic and display blocks.

Parameters:
- DECK_SIZE, 108, number of cards in the deck and of entries in i_deck.
- ID_W, 7, card-ID width; must satisfy 2^ID_W >= DECK_SIZE.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load  in  1  one-cycle pulse: capture i_deck and reset the pile pointer.
- i_deck  in  DECK_SIZE x ID_W  unpacked array; shuffled card IDs, index 0 is the top card.
- i_req  in  1  draw request; accepted only while o_req_ready=1.
- i_req_n  in  3  number of cards requested, legal values 1..4; 0 is treated as 1 and values above 4 as 4.
- o_req_ready  out  1  dealer is idle with a loaded pile.
- o_card_valid  out  1  o_card and o_card_id are valid.
- i_card_ready  in  1  consumer accepts the card.
- o_card  out  6  {color, value}.
- o_card_id  out  ID_W  raw card ID.
- o_last  out  1  the current card is the final card of this request.
- o_remaining  out  ID_W  cards still in the pile.
- o_empty  out  1  o_remaining==0.
- o_short  out  1  sticky flag: a request asked for more cards than remained; cleared by i_load.

Behaviour:
- Reset values:
  - state S_UNLOADED; pointer 0; o_remaining 0; o_empty 1.
  - o_req_ready 0, o_card_valid 0, o_last 0, o_short 0; o_card 0, o_card_id 0.
  - The deck register is cleared to 0.
- ID decode, pure combinational on the registered pile entry:
  - ID<100: color = ID/25 (0 red, 1 yellow, 2 green, 3 blue). With r = ID mod 25: r==0 gives value 0; otherwise value = (r+1)>>1. This yields 1-9, 10 skip, 11 reverse, 12 draw two.
  - 100-103: {0,13} wild. 104-107: {0,14} wild draw four.
  - IDs >=108 decode to {0,15}, the illegal marker.
  - Implement the division by 25 with comparators; no divider.
- States:
  - S_UNLOADED: i_load moves to S_IDLE. i_req is ignored.
  - S_IDLE: o_req_ready=1.
    - i_req with o_remaining>0: latch n = min(clamped i_req_n, o_remaining). Set o_short if clamped i_req_n > o_remaining. Go to S_DEAL.
    - i_req with o_remaining==0: set o_short and stay in S_IDLE.
  - S_DEAL: o_card_valid=1 and o_card = decode(deck[ptr]).
    - On valid&&ready: ptr+1, o_remaining-1, n-1.
    - o_last=1 when n==1. The handshake on the last card returns to S_IDLE.
    - Outputs hold stable while valid&&!ready.
- Latency:
  - The first card is valid in the cycle after the i_req acceptance edge.
  - Back-to-back cards are dealt at 1 per cycle while i_card_ready=1.
- i_load in any state aborts the current request:
  - Deck is captured; ptr=0; o_remaining=DECK_SIZE; o_short=0; go to S_IDLE.
  - o_card_valid drops in the next cycle. i_load has priority over i_req and over the handshake in the same cycle.
- Pointer never wraps. When o_remaining reaches 0, o_empty=1; only i_load refills the pile.
- i_req while not in S_IDLE is ignored (not queued).
- Asynchronous reset in mid-deal returns everything to the reset values immediately; no card is delivered after reset.

Decomposition:
- Package uno_pkg:
  - color enum (RED=0, YELLOW=1, GREEN=2, BLUE=3).
  - value constants (SKIP=10, REVERSE=11, DRAW2=12, WILD=13, WILD4=14, ILLEGAL=15).
  - card_t packed struct {color, value}.
  - DECK_SIZE.
  - Dealer state enum.
- Sub-module uno_card_decode (combinational ID -> card_t), reused by the display and scoring blocks.

Test Plan:
- Identity deck load, then 5 single draws with i_card_ready=1.
  - Cards in order: {0,0}, {0,1}, {0,1}, {0,2}, {0,2}.
  - o_remaining ends at 103.
- Deck with [0]=24, [1]=25, [2]=100, [3]=107, then i_req_n=4.
  - Four consecutive cycles: {0,12}, {1,0}, {0,13}, {0,14}.
  - o_last only on the 4th card; back in S_IDLE; o_remaining=104.
- Backpressure: i_card_ready low for 3 cycles during a 2-card draw.
  - o_card stays stable and o_remaining is unchanged until the handshake.
  - No card is lost or duplicated.
- Exhaustion: draw 106 cards, then i_req_n=4.
  - Exactly 2 cards are delivered, o_short=1, o_empty=1.
  - A further i_req is ignored and o_short stays 1.
- i_load asserted while the 2nd card of a 4-card draw is pending.
  - o_card_valid drops next cycle; o_remaining=108; ptr=0; o_short cleared.
  - The next draw returns new deck[0].
- Reset in mid-deal: assert i_rst_n=0 during S_DEAL.
  - o_card_valid=0 immediately, o_req_ready=0, o_empty=1.
  - i_req is ignored until i_load.
